// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl
// Brief    : Multi-cycle main controller for the MIPS datapath. It steps each
//            instruction through IF/ID/EXE/MEM/WB, decodes every datapath
//            control from (state, OpCode, Funct), counts retired instructions
//            and traps on illegal opcodes.
//            Optional macro MEM_WAIT_EN: MEM stalls until dm_ready is high.
//            Without the macro, dm_ready is ignored and MEM takes one cycle.
// Revision : 1.0 - initial release
// ============================================================================
module mc_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,        // asynchronous, active-low
    input  logic [5:0]       OpCode,
    input  logic [5:0]       Funct,
    input  logic             Zero,
    input  logic             dm_ready,
    output logic             PCWrEn,
    output logic [1:0]       PCWr,
    output logic             IRWr,
    output logic             RegDst,
    output logic             RegW,
    output logic             MemR,
    output logic             MemW,
    output logic             Mem2R,
    output logic             Alusrc,
    output logic [1:0]       EXTOp,
    output logic [4:0]       Aluctrl,
    output logic [1:0]       jump,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired,
    output logic             illegal
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EXE  = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_TRAP = 3'd7
    } state_t;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_JAL   = 6'b000011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_BNE   = 6'b000101;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_ORI   = 6'b001101;
    localparam logic [5:0] c_OP_LUI   = 6'b001111;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;

    localparam logic [5:0] c_FN_ADD   = 6'b100000;
    localparam logic [5:0] c_FN_SUB   = 6'b100010;
    localparam logic [5:0] c_FN_AND   = 6'b100100;
    localparam logic [5:0] c_FN_OR    = 6'b100101;
    localparam logic [5:0] c_FN_SLT   = 6'b101010;
    localparam logic [5:0] c_FN_SLL   = 6'b000000;
    localparam logic [5:0] c_FN_SRL   = 6'b000010;
    localparam logic [5:0] c_FN_JR    = 6'b001000;

    localparam logic [4:0] c_ALU_NOP  = 5'b00000;
    localparam logic [4:0] c_ALU_ADD  = 5'b00001;
    localparam logic [4:0] c_ALU_SUB  = 5'b00010;
    localparam logic [4:0] c_ALU_AND  = 5'b00011;
    localparam logic [4:0] c_ALU_OR   = 5'b00100;
    localparam logic [4:0] c_ALU_SLT  = 5'b00101;
    localparam logic [4:0] c_ALU_LUI  = 5'b00110;
    localparam logic [4:0] c_ALU_SLL  = 5'b00111;
    localparam logic [4:0] c_ALU_SRL  = 5'b01000;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               illegal_q, illegal_d;

    // Opcode class decode
    logic w_is_r, w_is_j, w_is_jal, w_is_jr, w_is_beq, w_is_bne;
    logic w_is_lw, w_is_sw, w_legal;
    logic w_r_ok;
    logic w_mem_done;

    // Datapath controls before the reset gate on the enables
    logic       w_pcwren, w_irwr, w_regw, w_memr, w_memw;
    logic       w_regdst, w_mem2r, w_alusrc;
    logic [1:0] w_pcwr, w_extop, w_jump;
    logic [4:0] w_aluctrl;
    logic       w_retire;

    // ALU setup implied by the instruction, reused in EXE, MEM and WB
    logic       w_op_alusrc;
    logic [1:0] w_op_extop;
    logic [4:0] w_op_alu;

    assign w_is_r   = (OpCode == c_OP_RTYPE);
    assign w_is_j   = (OpCode == c_OP_J);
    assign w_is_jal = (OpCode == c_OP_JAL);
    assign w_is_jr  = w_is_r && (Funct == c_FN_JR);
    assign w_is_beq = (OpCode == c_OP_BEQ);
    assign w_is_bne = (OpCode == c_OP_BNE);
    assign w_is_lw  = (OpCode == c_OP_LW);
    assign w_is_sw  = (OpCode == c_OP_SW);

`ifdef MEM_WAIT_EN
    assign w_mem_done = dm_ready;
`else
    // Without the wait handshake the memory always completes in one cycle.
    logic w_unused_dm_ready;
    assign w_unused_dm_ready = dm_ready;
    assign w_mem_done        = 1'b1;
`endif

    // Instruction legality and the ALU operation each instruction uses
    always_comb begin
        w_r_ok      = 1'b0;
        w_legal     = 1'b0;
        w_op_alusrc = 1'b0;
        w_op_extop  = 2'b00;
        w_op_alu    = c_ALU_NOP;
        case (Funct)
            c_FN_ADD, c_FN_SUB, c_FN_AND, c_FN_OR,
            c_FN_SLT, c_FN_SLL, c_FN_SRL, c_FN_JR: w_r_ok = 1'b1;
            default:                               w_r_ok = 1'b0;
        endcase
        case (OpCode)
            c_OP_RTYPE: begin
                w_legal = w_r_ok;
                case (Funct)
                    c_FN_ADD: w_op_alu = c_ALU_ADD;
                    c_FN_SUB: w_op_alu = c_ALU_SUB;
                    c_FN_AND: w_op_alu = c_ALU_AND;
                    c_FN_OR:  w_op_alu = c_ALU_OR;
                    c_FN_SLT: w_op_alu = c_ALU_SLT;
                    c_FN_SLL: w_op_alu = c_ALU_SLL;
                    c_FN_SRL: w_op_alu = c_ALU_SRL;
                    default:  w_op_alu = c_ALU_NOP;
                endcase
            end
            c_OP_J, c_OP_JAL: w_legal = 1'b1;
            c_OP_BEQ, c_OP_BNE: begin
                w_legal    = 1'b1;
                w_op_extop = 2'b01;
                w_op_alu   = c_ALU_SUB;
            end
            c_OP_ADDI, c_OP_LW, c_OP_SW: begin
                w_legal     = 1'b1;
                w_op_alusrc = 1'b1;
                w_op_extop  = 2'b01;
                w_op_alu    = c_ALU_ADD;
            end
            c_OP_ORI: begin
                w_legal     = 1'b1;
                w_op_alusrc = 1'b1;
                w_op_extop  = 2'b00;
                w_op_alu    = c_ALU_OR;
            end
            c_OP_LUI: begin
                w_legal     = 1'b1;
                w_op_alusrc = 1'b1;
                w_op_extop  = 2'b10;
                w_op_alu    = c_ALU_LUI;
            end
            default: w_legal = 1'b0;
        endcase
    end

    // Per-state control decode and next-state / retire selection
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        w_retire  = 1'b0;
        w_pcwren  = 1'b0;
        w_pcwr    = 2'b00;
        w_irwr    = 1'b0;
        w_regdst  = 1'b0;
        w_regw    = 1'b0;
        w_memr    = 1'b0;
        w_memw    = 1'b0;
        w_mem2r   = 1'b0;
        w_alusrc  = 1'b0;
        w_extop   = 2'b00;
        w_aluctrl = c_ALU_NOP;
        w_jump    = 2'b00;
        case (state_q)
            S_IF: begin
                w_irwr   = 1'b1;
                w_pcwren = 1'b1;
                w_pcwr   = 2'b00;
                state_d  = S_ID;
            end
            S_ID: begin
                if (!w_legal) begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end else if (w_is_j) begin
                    w_pcwren = 1'b1;
                    w_pcwr   = 2'b10;
                    w_jump   = 2'b01;
                    w_retire = 1'b1;
                    state_d  = S_IF;
                end else if (w_is_jal) begin
                    w_pcwren = 1'b1;
                    w_pcwr   = 2'b10;
                    w_jump   = 2'b10;
                    w_regw   = 1'b1;
                    w_retire = 1'b1;
                    state_d  = S_IF;
                end else if (w_is_jr) begin
                    w_pcwren = 1'b1;
                    w_pcwr   = 2'b11;
                    w_jump   = 2'b11;
                    w_retire = 1'b1;
                    state_d  = S_IF;
                end else begin
                    state_d  = S_EXE;
                end
            end
            S_EXE: begin
                w_alusrc  = w_op_alusrc;
                w_extop   = w_op_extop;
                w_aluctrl = w_op_alu;
                if (w_is_beq || w_is_bne) begin
                    // Branch resolves here; PC reloads only when taken.
                    if ((w_is_beq && Zero) || (w_is_bne && !Zero)) begin
                        w_pcwren = 1'b1;
                        w_pcwr   = 2'b01;
                    end
                    w_retire = 1'b1;
                    state_d  = S_IF;
                end else if (w_is_lw || w_is_sw) begin
                    state_d  = S_MEM;
                end else begin
                    state_d  = S_WB;
                end
            end
            S_MEM: begin
                w_alusrc  = w_op_alusrc;
                w_extop   = w_op_extop;
                w_aluctrl = w_op_alu;
                if (w_is_lw) begin
                    w_memr = 1'b1;
                    if (w_mem_done) state_d = S_WB;
                end else if (w_is_sw) begin
                    w_memw = 1'b1;
                    if (w_mem_done) begin
                        w_retire = 1'b1;
                        state_d  = S_IF;
                    end
                end else begin
                    state_d = S_IF;
                end
            end
            S_WB: begin
                w_alusrc  = w_op_alusrc;
                w_extop   = w_op_extop;
                w_aluctrl = w_op_alu;
                w_regw    = 1'b1;
                w_regdst  = !w_is_r;
                w_mem2r   = w_is_lw;
                w_retire  = 1'b1;
                state_d   = S_IF;
            end
            S_TRAP: begin
                state_d   = S_TRAP;
                illegal_d = 1'b1;
            end
            default: state_d = S_IF;
        endcase
        retired_d = w_retire ? (retired_q + CNT_W'(1)) : retired_q;
    end

    // State, retire counter and trap flag registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IF;
            retired_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
        end
    end

    // Enables are forced low while reset is held so no write slips through.
    assign PCWrEn  = w_pcwren & rst;
    assign IRWr    = w_irwr   & rst;
    assign RegW    = w_regw   & rst;
    assign MemR    = w_memr   & rst;
    assign MemW    = w_memw   & rst;
    assign PCWr    = w_pcwr;
    assign RegDst  = w_regdst;
    assign Mem2R   = w_mem2r;
    assign Alusrc  = w_alusrc;
    assign EXTOp   = w_extop;
    assign Aluctrl = w_aluctrl;
    assign jump    = w_jump;
    assign state   = state_q;
    assign retired = retired_q;
    assign illegal = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_ctrl
// Brief    : Scoreboard bench for mc_ctrl. Directed instruction sequences push
//            hand-computed per-cycle expectations; a negedge monitor pops and
//            compares them against the DUT outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_ctrl;

    localparam int CNT_W = 3;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BAD  = 6'b111111;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_BAD  = 6'b111111;

    logic             clk, rst;
    logic [5:0]       OpCode, Funct;
    logic             Zero, dm_ready;
    logic             PCWrEn, IRWr, RegDst, RegW, MemR, MemW, Mem2R, Alusrc;
    logic [1:0]       PCWr, EXTOp, jump;
    logic [4:0]       Aluctrl;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired;
    logic             illegal;

    mc_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .OpCode(OpCode), .Funct(Funct), .Zero(Zero),
        .dm_ready(dm_ready), .PCWrEn(PCWrEn), .PCWr(PCWr), .IRWr(IRWr),
        .RegDst(RegDst), .RegW(RegW), .MemR(MemR), .MemW(MemW), .Mem2R(Mem2R),
        .Alusrc(Alusrc), .EXTOp(EXTOp), .Aluctrl(Aluctrl), .jump(jump),
        .state(state), .retired(retired), .illegal(illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        int          id;
        logic [2:0]  st;
        logic [18:0] ctrl;
        logic [2:0]  ret;
        logic        ill;
    } exp_t;

    exp_t        sb[$];
    exp_t        m_e;
    int          total = 0;
    int          bad   = 0;
    int          step_id = 0;
    logic [2:0]  exp_ret = 3'd0;
    logic [18:0] act_ctrl;

    assign act_ctrl = {PCWrEn, PCWr, IRWr, RegDst, RegW, MemR, MemW, Mem2R,
                       Alusrc, EXTOp, Aluctrl, jump};

    // Control vector: pcwren,pcwr,irwr,regdst,regw,memr,memw,mem2r,alusrc,extop,alu,jump
    function automatic logic [18:0] mk(input logic pcwren, input logic [1:0] pcwr,
                                       input logic irwr, input logic regdst,
                                       input logic regw, input logic memr,
                                       input logic memw, input logic mem2r,
                                       input logic alusrc, input logic [1:0] extop,
                                       input logic [4:0] alu, input logic [1:0] jmp);
        return {pcwren, pcwr, irwr, regdst, regw, memr, memw, mem2r, alusrc,
                extop, alu, jmp};
    endfunction

    logic [18:0] C0, c_if, c_ex_imm, c_wb_imm, c_mem_lw, c_wb_lw, c_mem_sw;
    logic [18:0] c_ex_add, c_wb_add, c_br_take, c_br_not, c_j, c_jal, c_jr;
    logic [18:0] c_ex_ori, c_wb_ori, c_ex_slt, c_wb_slt, c_ex_lui, c_wb_lui;

    task automatic check(input string nm, input int id, input logic [31:0] act,
                         input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s step=%0d actual=%0h required=%0h", nm, id, act, exp);
        end
    endtask

    // Monitor: every negedge with a pending expectation is one DUT observation
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            m_e = sb.pop_front();
            check("state",   m_e.id, 32'(state),    32'(m_e.st));
            check("ctrl",    m_e.id, 32'(act_ctrl), 32'(m_e.ctrl));
            check("retired", m_e.id, 32'(retired),  32'(m_e.ret));
            check("illegal", m_e.id, 32'(illegal),  32'(m_e.ill));
        end
    end

    task automatic step(input logic r, input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input logic rdy, input logic [2:0] st,
                        input logic [18:0] c, input logic ret, input logic ill);
        exp_t e;
        rst = r; OpCode = op; Funct = fn; Zero = z; dm_ready = rdy;
        if (!r) exp_ret = 3'd0;
        step_id = step_id + 1;
        e.id = step_id; e.st = st; e.ctrl = c; e.ret = exp_ret; e.ill = ill;
        sb.push_back(e);
        if (ret) exp_ret = exp_ret + 3'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic ex(input logic [5:0] op, input logic [5:0] fn, input logic z,
                      input logic [2:0] st, input logic [18:0] c, input logic ret);
        step(1'b1, op, fn, z, 1'b1, st, c, ret, 1'b0);
    endtask

    task automatic fetch_decode(input logic [5:0] op, input logic [5:0] fn);
        ex(op, fn, 1'b0, 3'd0, c_if, 1'b0);
        ex(op, fn, 1'b0, 3'd1, C0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog step=%0d actual=timeout required=finish", step_id);
        $fatal(1, "watchdog expired");
    end

    initial begin
        C0        = '0;
        c_if      = mk(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 2'b00);
        c_ex_imm  = mk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 5'd1, 2'b00);
        c_wb_imm  = mk(1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 5'd1, 2'b00);
        c_mem_lw  = mk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 5'd1, 2'b00);
        c_wb_lw   = mk(1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 5'd1, 2'b00);
        c_mem_sw  = mk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 5'd1, 2'b00);
        c_ex_add  = mk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd1, 2'b00);
        c_wb_add  = mk(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd1, 2'b00);
        c_br_take = mk(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 5'd2, 2'b00);
        c_br_not  = mk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 5'd2, 2'b00);
        c_j       = mk(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 2'b01);
        c_jal     = mk(1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 2'b10);
        c_jr      = mk(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 2'b11);
        c_ex_ori  = mk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 5'd4, 2'b00);
        c_wb_ori  = mk(1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 5'd4, 2'b00);
        c_ex_slt  = mk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd5, 2'b00);
        c_wb_slt  = mk(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd5, 2'b00);
        c_ex_lui  = mk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 5'd6, 2'b00);
        c_wb_lui  = mk(1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 5'd6, 2'b00);

        rst = 1'b0; OpCode = OP_ADDI; Funct = 6'd0; Zero = 1'b0; dm_ready = 1'b0;
        @(posedge clk);
        #1;
        // Held in reset: IF state, every enable low, counters clear
        step(1'b0, OP_ADDI, 6'd0, 1'b0, 1'b0, 3'd0, C0, 1'b0, 1'b0);

        // ADDI (4), LW (5), SW (4), ADD (4): retired reaches 4 after 17 cycles
        fetch_decode(OP_ADDI, 6'd0);
        ex(OP_ADDI, 6'd0, 1'b0, 3'd2, c_ex_imm, 1'b0);
        ex(OP_ADDI, 6'd0, 1'b0, 3'd4, c_wb_imm, 1'b1);
        fetch_decode(OP_LW, 6'd0);
        ex(OP_LW, 6'd0, 1'b0, 3'd2, c_ex_imm, 1'b0);
        ex(OP_LW, 6'd0, 1'b0, 3'd3, c_mem_lw, 1'b0);
        ex(OP_LW, 6'd0, 1'b0, 3'd4, c_wb_lw, 1'b1);
        fetch_decode(OP_SW, 6'd0);
        ex(OP_SW, 6'd0, 1'b0, 3'd2, c_ex_imm, 1'b0);
        ex(OP_SW, 6'd0, 1'b0, 3'd3, c_mem_sw, 1'b1);
        fetch_decode(OP_R, FN_ADD);
        ex(OP_R, FN_ADD, 1'b0, 3'd2, c_ex_add, 1'b0);
        ex(OP_R, FN_ADD, 1'b0, 3'd4, c_wb_add, 1'b1);

        // Branches: taken/not-taken for BEQ and BNE; the 8th retire wraps 3-bit count
        fetch_decode(OP_BEQ, 6'd0);
        ex(OP_BEQ, 6'd0, 1'b1, 3'd2, c_br_take, 1'b1);
        fetch_decode(OP_BEQ, 6'd0);
        ex(OP_BEQ, 6'd0, 1'b0, 3'd2, c_br_not, 1'b1);
        fetch_decode(OP_BNE, 6'd0);
        ex(OP_BNE, 6'd0, 1'b1, 3'd2, c_br_not, 1'b1);
        fetch_decode(OP_BNE, 6'd0);
        ex(OP_BNE, 6'd0, 1'b0, 3'd2, c_br_take, 1'b1);

        // Jumps resolve in ID and retire after two cycles
        ex(OP_JAL, 6'd0, 1'b0, 3'd0, c_if, 1'b0);
        ex(OP_JAL, 6'd0, 1'b0, 3'd1, c_jal, 1'b1);
        ex(OP_J, 6'd0, 1'b0, 3'd0, c_if, 1'b0);
        ex(OP_J, 6'd0, 1'b0, 3'd1, c_j, 1'b1);
        ex(OP_R, FN_JR, 1'b0, 3'd0, c_if, 1'b0);
        ex(OP_R, FN_JR, 1'b0, 3'd1, c_jr, 1'b1);

        // ORI, SLT, LUI: zero-extend/OR, R-type SLT, lui-extend
        fetch_decode(OP_ORI, 6'd0);
        ex(OP_ORI, 6'd0, 1'b0, 3'd2, c_ex_ori, 1'b0);
        ex(OP_ORI, 6'd0, 1'b0, 3'd4, c_wb_ori, 1'b1);
        fetch_decode(OP_R, FN_SLT);
        ex(OP_R, FN_SLT, 1'b0, 3'd2, c_ex_slt, 1'b0);
        ex(OP_R, FN_SLT, 1'b0, 3'd4, c_wb_slt, 1'b1);
        fetch_decode(OP_LUI, 6'd0);
        ex(OP_LUI, 6'd0, 1'b0, 3'd2, c_ex_lui, 1'b0);
        ex(OP_LUI, 6'd0, 1'b0, 3'd4, c_wb_lui, 1'b1);

`ifdef MEM_WAIT_EN
        // LW stalls three cycles in MEM, then one ready cycle, then WB
        fetch_decode(OP_LW, 6'd0);
        ex(OP_LW, 6'd0, 1'b0, 3'd2, c_ex_imm, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b1, OP_LW, 6'd0, 1'b0, 1'b0, 3'd3, c_mem_lw, 1'b0, 1'b0);
        ex(OP_LW, 6'd0, 1'b0, 3'd3, c_mem_lw, 1'b0);
        ex(OP_LW, 6'd0, 1'b0, 3'd4, c_wb_lw, 1'b1);
        // SW holds MemW while not ready, retires on the ready cycle
        fetch_decode(OP_SW, 6'd0);
        ex(OP_SW, 6'd0, 1'b0, 3'd2, c_ex_imm, 1'b0);
        step(1'b1, OP_SW, 6'd0, 1'b0, 1'b0, 3'd3, c_mem_sw, 1'b0, 1'b0);
        ex(OP_SW, 6'd0, 1'b0, 3'd3, c_mem_sw, 1'b1);
`else
        // dm_ready low is ignored: MEM lasts exactly one cycle
        fetch_decode(OP_LW, 6'd0);
        ex(OP_LW, 6'd0, 1'b0, 3'd2, c_ex_imm, 1'b0);
        step(1'b1, OP_LW, 6'd0, 1'b0, 1'b0, 3'd3, c_mem_lw, 1'b0, 1'b0);
        step(1'b1, OP_LW, 6'd0, 1'b0, 1'b0, 3'd4, c_wb_lw, 1'b1, 1'b0);
`endif

        // Reset asserted 1 ns into the EXE cycle: IF, enables off, count cleared
        fetch_decode(OP_ADDI, 6'd0);
        step(1'b0, OP_ADDI, 6'd0, 1'b0, 1'b1, 3'd0, C0, 1'b0, 1'b0);
        ex(OP_ADDI, 6'd0, 1'b0, 3'd0, c_if, 1'b0);
        ex(OP_ADDI, 6'd0, 1'b0, 3'd1, C0, 1'b0);
        ex(OP_ADDI, 6'd0, 1'b0, 3'd2, c_ex_imm, 1'b0);
        ex(OP_ADDI, 6'd0, 1'b0, 3'd4, c_wb_imm, 1'b1);

        // Illegal opcode: TRAP with no enables for 20 cycles, cleared by reset
        fetch_decode(OP_BAD, 6'd0);
        for (int i = 0; i < 20; i++)
            step(1'b1, OP_BAD, 6'd0, i[0], i[1], 3'd7, C0, 1'b0, 1'b1);
        step(1'b0, OP_BAD, 6'd0, 1'b0, 1'b1, 3'd0, C0, 1'b0, 1'b0);

        // Illegal R-type funct also traps
        fetch_decode(OP_R, FN_BAD);
        step(1'b1, OP_R, FN_BAD, 1'b0, 1'b1, 3'd7, C0, 1'b0, 1'b1);
        step(1'b0, OP_R, FN_BAD, 1'b0, 1'b1, 3'd0, C0, 1'b0, 1'b0);
        ex(OP_ADDI, 6'd0, 1'b0, 3'd0, c_if, 1'b0);

        @(negedge clk);
        #1;
        check("scoreboard_drained", 0, 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle main controller for the MIPS datapath. It replaces the single-cycle decoder.
- Sequences each instruction through IF/ID/EXE/MEM/WB and drives the PC, IR, RF, ALU, EXT and DM controls, one step per clk.
- Counts retired instructions and traps illegal opcodes.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- OpCode  in  6  instr[31:26] from IR
- Funct  in  6  instr[5:0] from IR
- Zero  in  1  ALU zero flag
- dm_ready  in  1  DM access done (used only with MEM_WAIT_EN)
- PCWrEn  out  1  PC load enable
- PCWr  out  2  PC source: 00 PC+4, 01 branch target, 10 J/JAL target, 11 ra (JR)
- IRWr  out  1  IR load enable
- RegDst  out  1  1 selects rt as A3, 0 selects rd
- RegW  out  1  RF write enable
- MemR  out  1  DM read
- MemW  out  1  DM write
- Mem2R  out  1  WD from DM
- Alusrc  out  1  ALU B from Imm32
- EXTOp  out  2  00 zero-extend, 01 sign-extend, 10 lui (imm<<16)
- Aluctrl  out  5  00000 NOP, 00001 ADD, 00010 SUB, 00011 AND, 00100 OR, 00101 SLT, 00110 LUI, 00111 SLL, 01000 SRL
- jump  out  2  00 none, 01 J, 10 JAL (A3=31), 11 JR
- state  out  3  current state, for debug
- retired  out  CNT_W  instructions completed
- illegal  out  1  trap flag

Behaviour:
- State encoding: IF=0, ID=1, EXE=2, MEM=3, WB=4, TRAP=7.
- Reset (rst=0, asynchronous): state=IF, retired=0, illegal=0.
- While in reset, all enables are 0: PCWrEn, IRWr, RegW, MemR, MemW.
- All outputs are decoded combinationally from state, OpCode and Funct. Only state, retired and illegal are registered.
- Unlisted outputs are 0 in every state.
- IF: IRWr=1, PCWrEn=1, PCWr=00. Next state is ID.
- ID, illegal opcode/funct: next state TRAP, illegal<=1.
- ID, J (000010): PCWrEn=1, PCWr=10, jump=01, retire. Next state IF. Total 2 cycles.
- ID, JAL (000011): PCWrEn=1, PCWr=10, jump=10, RegW=1, retire. Next state IF. Total 2 cycles.
- ID, JR (R-type, funct 001000): PCWrEn=1, PCWr=11, jump=11, retire. Next state IF.
- ID, all other legal instructions: next state EXE.
- EXE, R-type: Alusrc=0, Aluctrl per funct (100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, 000000 SLL, 000010 SRL). Next state WB.
- EXE, ADDI (001000): Alusrc=1, EXTOp=01, ADD. Next state WB.
- EXE, ORI (001101): Alusrc=1, EXTOp=00, OR. Next state WB.
- EXE, LUI (001111): Alusrc=1, EXTOp=10, LUI. Next state WB.
- EXE, LW (100011) / SW (101011): Alusrc=1, EXTOp=01, ADD. Next state MEM.
- EXE, BEQ (000100) / BNE (000101): Aluctrl=SUB, EXTOp=01.
  - PCWrEn=1 and PCWr=01 iff (BEQ and Zero) or (BNE and not Zero).
  - Retire. Next state IF. Total 3 cycles.
- MEM, LW: MemR=1, Alusrc=1, ADD held. Next state WB.
- MEM, SW: MemW=1 for exactly one cycle, retire. Next state IF.
- WB: RegW=1; ALU controls held as in EXE.
  - RegDst=0 for R-type, 1 for I-type.
  - Mem2R=1 for LW only.
  - Retire. Next state IF.
- Cycle counts: R/I-ALU 4, LW 5, SW 4, branch 3, J/JAL/JR 2.
- Retire: retired increments by 1 on the last cycle of each instruction. It wraps at 2^CNT_W−1 → 0.
- TRAP: all enables 0, illegal=1. Held until rst is asserted.
- Reset mid-instruction: state returns to IF immediately. No partial RF/DM write is permitted after the rst edge.

Optional Feature:
- Macro: MEM_WAIT_EN.
- Defined:
  - In MEM, LW holds MemR=1 while dm_ready=0. It advances to WB on the first cycle with dm_ready=1.
  - SW holds MemW=1 until dm_ready=1, then retires.
  - retired does not increment during wait cycles.
- Undefined: dm_ready is ignored. MEM always lasts exactly 1 cycle.

Test Plan:
- Reset pulse mid-EXE → state=0, retired=0, all enables 0 within the same cycle, before the next clk edge.
- Sequence ADDI, LW, SW, R-type ADD → states 0-1-2-4, 0-1-2-3-4, 0-1-2-3, 0-1-2-4; retired=4 after 17 cycles.
- BEQ with Zero=1 → PCWrEn=1, PCWr=01 in EXE. BEQ with Zero=0 → PCWrEn=0. BNE gives the inverse.
- JAL → in ID: RegW=1, jump=10, PCWr=10, PCWrEn=1; next state IF. JR (funct 001000) → PCWr=11, jump=11.
- OpCode 111111 → TRAP, illegal=1, no enables for 20 cycles, cleared only by rst=0.
- MEM_WAIT_EN with LW and dm_ready low for 3 cycles → MemR held 4 cycles, WB on the 5th, retired +1 once.
